// File: rtl/caf_peak_select_if.sv
// caf_peak_select_if
//   Bundles the result-set input handshake, the detection threshold and the
//   peak-result output handshake of caf_peak_select.
//   slave  : the peak selector's view (accepts sets, produces results)
//   master : the upstream/downstream view (supplies sets, consumes results)
// Signals:
//   m_axis_tvalid / s_axis_tready        result-set handshake
//   m_axis_mag, m_axis_index, threshold  per-bin magnitudes, lags, threshold
//   s_axis_tvalid / m_axis_tready        peak-result handshake
//   s_axis_peak_freq/index/mag, s_axis_detect  peak result word
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; a source holds its payload stable while valid is high
// and ready is low, and never waits on ready before raising valid.
interface caf_peak_select_if #(
    parameter int foa_len      = 8,
    parameter int foa_len_bits = 3,
    parameter int mag_bits     = 24,
    parameter int index_bits   = 10
);
    logic                           m_axis_tvalid;
    logic                           s_axis_tready;
    logic [foa_len*mag_bits-1:0]    m_axis_mag;
    logic [foa_len*index_bits-1:0]  m_axis_index;
    logic [mag_bits-1:0]            threshold;
    logic                           s_axis_tvalid;
    logic                           m_axis_tready;
    logic [foa_len_bits-1:0]        s_axis_peak_freq;
    logic [index_bits-1:0]          s_axis_peak_index;
    logic [mag_bits-1:0]            s_axis_peak_mag;
    logic                           s_axis_detect;

    modport slave (
        input  m_axis_tvalid, m_axis_mag, m_axis_index, threshold, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, s_axis_peak_freq, s_axis_peak_index,
               s_axis_peak_mag, s_axis_detect
    );

    modport master (
        output m_axis_tvalid, m_axis_mag, m_axis_index, threshold, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, s_axis_peak_freq, s_axis_peak_index,
               s_axis_peak_mag, s_axis_detect
    );
endinterface

// File: rtl/caf_peak_select.sv
// caf_peak_select
//   FIND_MAX stage after the CAF correlator. Latches one complete set of
//   per-bin peaks, scans the bins one per cycle for the global maximum
//   (ties keep the lower bin) and presents bin, lag, magnitude and a
//   detect flag (magnitude > threshold) as a single result beat.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        caf_peak_select_if.slave (input set + threshold, result)
//   dbg_state  current FSM state (0 IDLE, 1 SCAN, 2 OUTPUT)
module caf_peak_select #(
    parameter int foa_len      = 8,
    parameter int foa_len_bits = 3,
    parameter int mag_bits     = 24,
    parameter int index_bits   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    caf_peak_select_if.slave     bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [foa_len_bits-1:0] last_ptr = foa_len_bits'(foa_len - 1);

    state_t                  state, state_next;
    logic [mag_bits-1:0]     mag_arr [foa_len];
    logic [index_bits-1:0]   idx_arr [foa_len];
    logic [mag_bits-1:0]     thr_q;
    logic [mag_bits-1:0]     best_mag;
    logic [index_bits-1:0]   best_index;
    logic [foa_len_bits-1:0] best_bin;
    logic [foa_len_bits-1:0] ptr;
    logic                    tready_q, tvalid_q, detect_q;
    logic [foa_len_bits-1:0] peak_freq;
    logic [index_bits-1:0]   peak_index;
    logic [mag_bits-1:0]     peak_mag;

    logic                    accept, scan_last;
    logic                    take;
    logic [mag_bits-1:0]     win_mag;
    logic [index_bits-1:0]   win_index;
    logic [foa_len_bits-1:0] win_bin;

    // Next-state logic and handshake strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        scan_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m_axis_tvalid && tready_q) begin
                    accept     = 1'b1;
                    // A single bin needs no scan: bin 0 is the answer.
                    state_next = (foa_len == 1) ? OUTPUT : SCAN;
                end
            end
            SCAN: begin
                if (ptr == last_ptr) begin
                    scan_last  = 1'b1;
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (tvalid_q && bus.m_axis_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strictly-greater replacement keeps the lower bin on ties.
    always_comb begin
        take      = mag_arr[ptr] > best_mag;
        win_mag   = take ? mag_arr[ptr] : best_mag;
        win_index = take ? idx_arr[ptr] : best_index;
        win_bin   = take ? ptr          : best_bin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < foa_len; k++) begin
                mag_arr[k] <= '0;
                idx_arr[k] <= '0;
            end
            thr_q      <= '0;
            best_mag   <= '0;
            best_index <= '0;
            best_bin   <= '0;
            ptr        <= '0;
            tready_q   <= 1'b0;
            tvalid_q   <= 1'b0;
            detect_q   <= 1'b0;
            peak_freq  <= '0;
            peak_index <= '0;
            peak_mag   <= '0;
        end else begin
            // Ready is registered: high exactly while the next state is IDLE.
            tready_q <= (state_next == IDLE);

            if (accept) begin
                for (int k = 0; k < foa_len; k++) begin
                    mag_arr[k] <= bus.m_axis_mag[k*mag_bits +: mag_bits];
                    idx_arr[k] <= bus.m_axis_index[k*index_bits +: index_bits];
                end
                thr_q      <= bus.threshold;
                best_mag   <= bus.m_axis_mag[mag_bits-1:0];
                best_index <= bus.m_axis_index[index_bits-1:0];
                best_bin   <= '0;
                ptr        <= foa_len_bits'(1);
                if (foa_len == 1) begin
                    peak_freq  <= '0;
                    peak_index <= bus.m_axis_index[index_bits-1:0];
                    peak_mag   <= bus.m_axis_mag[mag_bits-1:0];
                    detect_q   <= bus.m_axis_mag[mag_bits-1:0] > bus.threshold;
                    tvalid_q   <= 1'b1;
                end
            end

            if (state == SCAN) begin
                best_mag   <= win_mag;
                best_index <= win_index;
                best_bin   <= win_bin;
                if (scan_last) begin
                    peak_freq  <= win_bin;
                    peak_index <= win_index;
                    peak_mag   <= win_mag;
                    detect_q   <= win_mag > thr_q;
                    tvalid_q   <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end

            if (state == OUTPUT && tvalid_q && bus.m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready     = tready_q;
    assign bus.s_axis_tvalid     = tvalid_q;
    assign bus.s_axis_peak_freq  = peak_freq;
    assign bus.s_axis_peak_index = peak_index;
    assign bus.s_axis_peak_mag   = peak_mag;
    assign bus.s_axis_detect     = detect_q;
    assign dbg_state             = state;

endmodule

// File: tb/tb_caf_peak_select.sv
// tb_caf_peak_select
//   Bench for caf_peak_select: directed cases plus randomized result sets,
//   expected results queued at accept time and checked by a monitor when
//   the result beat is transferred.
module tb_caf_peak_select;

    localparam int FOA = 8;
    localparam int FB  = 3;
    localparam int MB  = 24;
    localparam int IB  = 10;
    localparam int W   = FB + IB + MB + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    caf_peak_select_if #(.foa_len(FOA), .foa_len_bits(FB), .mag_bits(MB), .index_bits(IB)) bus ();
    logic [1:0] dbg_state;

    caf_peak_select #(.foa_len(FOA), .foa_len_bits(FB), .mag_bits(MB), .index_bits(IB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           passes = 0;
    int           overlap = 0;
    int           last_hs = -100;
    logic         prev_tv = 1'b0;
    bit           rnd_bp = 1'b0;

    logic [MB-1:0] mags [FOA];
    logic [IB-1:0] lags [FOA];
    logic [MB-1:0] thr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: argmax with first-occurrence tie rule, detect = max > thr.
    function automatic logic [W-1:0] model();
        int best = 0;
        for (int k = 1; k < FOA; k++)
            if (mags[k] > mags[best]) best = k;
        return {FB'(best), lags[best], mags[best], (mags[best] > thr)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_axis_tvalid && bus.s_axis_tready) overlap++;
            if (bus.s_axis_tvalid && !prev_tv && acc_q.size() > 0)
                check("latency", 64'(cyc - acc_q[0]), 64'(FOA - 1));
            if (bus.s_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    check("peak_freq",  64'(bus.s_axis_peak_freq),  64'(e[W-1 -: FB]));
                    check("peak_index", 64'(bus.s_axis_peak_index), 64'(e[MB+IB : MB+1]));
                    check("peak_mag",   64'(bus.s_axis_peak_mag),   64'(e[MB:1]));
                    check("detect",     64'(bus.s_axis_detect),     64'(e[0]));
                end
                last_hs = cyc + 1;
            end
        end
        prev_tv = bus.s_axis_tvalid;
    end

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (rnd_bp) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic drive_set(input bit hold, output int acc_edge);
        int n = 0;
        for (int k = 0; k < FOA; k++) begin
            bus.m_axis_mag[k*MB +: MB]   = mags[k];
            bus.m_axis_index[k*IB +: IB] = lags[k];
        end
        bus.threshold     = thr;
        bus.m_axis_tvalid = 1'b1;
        acc_edge = -1;
        while (bus.s_axis_tready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 1, 0);
            bus.m_axis_tvalid = 1'b0;
        end else begin
            exp_q.push_back(model());
            acc_edge = cyc + 1;
            acc_q.push_back(acc_edge);
            @(posedge clk); #1;
            if (!hold) bus.m_axis_tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    function automatic logic [MB-1:0] rnd_mag();
        case ($urandom_range(0, 3))
            0:       return MB'($urandom_range(0, 3));
            1:       return {MB{1'b1}};
            default: return MB'($urandom);
        endcase
    endfunction

    task automatic rnd_set();
        for (int k = 0; k < FOA; k++) begin
            mags[k] = rnd_mag();
            lags[k] = IB'($urandom);
        end
        thr = rnd_mag();
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int acc_a, acc_b;
        logic [W-1:0] snap;

        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.m_axis_mag    = '0;
        bus.m_axis_index  = '0;
        bus.threshold     = '0;

        // Reset values
        #3;
        check("rst_tready", 64'(bus.s_axis_tready), 0);
        check("rst_tvalid", 64'(bus.s_axis_tvalid), 0);
        check("rst_result", 64'({bus.s_axis_peak_freq, bus.s_axis_peak_index,
                                 bus.s_axis_peak_mag, bus.s_axis_detect}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("tready_before_edge", 64'(bus.s_axis_tready), 0);
        @(posedge clk); #1;
        check("tready_after_edge", 64'(bus.s_axis_tready), 1);

        // Unique max
        mags = '{5, 9, 300, 7, 0, 12, 299, 1};
        for (int k = 0; k < FOA; k++) lags[k] = IB'(k * 10);
        thr = 100;
        drive_set(0, acc_a);
        drain();
        check("uniq_freq", 64'(bus.s_axis_peak_freq), 2);
        check("uniq_mag", 64'(bus.s_axis_peak_mag), 300);
        check("uniq_index", 64'(bus.s_axis_peak_index), 20);
        check("uniq_detect", 64'(bus.s_axis_detect), 1);

        // Tie, at threshold
        for (int k = 0; k < FOA; k++) mags[k] = 50;
        mags[3] = 80; mags[6] = 80; thr = 80;
        drive_set(0, acc_a);
        drain();
        check("tie_freq", 64'(bus.s_axis_peak_freq), 3);
        check("tie_detect", 64'(bus.s_axis_detect), 0);

        // Extremes
        for (int k = 0; k < FOA; k++) mags[k] = 0;
        mags[7] = {MB{1'b1}}; thr = 100;
        drive_set(0, acc_a);
        drain();
        check("max_freq", 64'(bus.s_axis_peak_freq), 7);
        check("max_mag", 64'(bus.s_axis_peak_mag), 64'h00FF_FFFF);
        for (int k = 0; k < FOA; k++) mags[k] = 0;
        thr = 0;
        drive_set(0, acc_a);
        drain();
        check("zero_freq", 64'(bus.s_axis_peak_freq), 0);
        check("zero_mag", 64'(bus.s_axis_peak_mag), 0);
        check("zero_detect", 64'(bus.s_axis_detect), 0);

        // Backpressure with input disturbance
        bus.m_axis_tready = 1'b0;
        rnd_set();
        drive_set(0, acc_a);
        begin
            int n = 0;
            while (bus.s_axis_tvalid !== 1'b1 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            check("bp_tvalid_seen", 64'(bus.s_axis_tvalid), 1);
        end
        snap = {bus.s_axis_peak_freq, bus.s_axis_peak_index, bus.s_axis_peak_mag, bus.s_axis_detect};
        for (int i = 0; i < 10; i++) begin
            bus.m_axis_mag    = {FOA{MB'($urandom)}};
            bus.threshold     = MB'($urandom);
            bus.m_axis_tvalid = 1'(i % 2);
            @(posedge clk); #1;
            check("bp_stable", 64'({bus.s_axis_peak_freq, bus.s_axis_peak_index,
                                    bus.s_axis_peak_mag, bus.s_axis_detect}), 64'(snap));
            check("bp_tvalid", 64'(bus.s_axis_tvalid), 1);
            check("bp_tready", 64'(bus.s_axis_tready), 0);
        end
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_tvalid", 64'(bus.s_axis_tvalid), 0);
        check("bp_done_tready", 64'(bus.s_axis_tready), 1);
        check("bp_delivered", 64'(exp_q.size()), 0);

        // Back-to-back sets with tvalid held
        rnd_set();
        drive_set(1, acc_a);
        rnd_set();
        drive_set(1, acc_b);
        bus.m_axis_tvalid = 1'b0;
        check("b2b_accept_gap", 64'(acc_b - last_hs), 1);
        drain();

        // Reset in the middle of a scan
        rnd_set();
        mags[0] = 24'h123456;
        drive_set(0, acc_a);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(bus.s_axis_tvalid), 0);
        check("mid_rst_tready", 64'(bus.s_axis_tready), 0);
        check("mid_rst_result", 64'({bus.s_axis_peak_freq, bus.s_axis_peak_index,
                                     bus.s_axis_peak_mag, bus.s_axis_detect}), 0);
        check("mid_rst_state", 64'(dbg_state), 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rnd_set();
        drive_set(0, acc_a);
        drain();

        // Randomized sets with random backpressure
        rnd_bp = 1'b1;
        for (int s = 0; s < 40; s++) begin
            rnd_set();
            drive_set(1'($urandom_range(0, 1)), acc_a);
            if ($urandom_range(0, 3) == 0) begin
                bus.m_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        bus.m_axis_tvalid = 1'b0;
        rnd_bp = 1'b0;
        bus.m_axis_tready = 1'b1;
        drain();

        check("valid_ready_overlap", 64'(overlap), 0);
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
